// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, FSM encoding, default width.
// Imported by the ALU and by the control unit.
package alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_iter_datapath.sv
// Iterative MUL/DIV registers, one bit per step.
// mode 0: shift-add multiply; mode 1: restoring divide.
module alu_iter_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result_next
);

    // acc: product / remainder
    // sa:  multiplicand / dividend-quotient
    // sb:  multiplier / divisor
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    assign mul_acc = acc_q + (sb_q[0] ? sa_q : '0);

    assign rem_sh = {acc_q, sa_q[WIDTH-1]};
    assign fits   = rem_sh >= {1'b0, sb_q};
    // Remainder stays below the divisor, so the top bit is always 0.
    assign rem_n  = fits ? WIDTH'(rem_sh - {1'b0, sb_q})
                         : rem_sh[WIDTH-1:0];
    assign quo_n  = {sa_q[WIDTH-2:0], fits};

    assign result_next = mode ? quo_n : mul_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            sa_q  <= '0;
            sb_q  <= '0;
        end else if (load) begin
            acc_q <= '0;
            sa_q  <= a;
            sb_q  <= b;
        end else if (step) begin
            if (mode) begin
                acc_q <= rem_n;
                sa_q  <= quo_n;
            end else begin
                acc_q <= mul_acc;
                sa_q  <= sa_q << 1;
                sb_q  <= sb_q >> 1;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU on a level start/done four-phase handshake.
// ADD/SUB finish on the capture edge, MUL/DIV iterate WIDTH steps.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    alu_state_t       state_q, state_n;
    logic [WIDTH-1:0] result_q, result_n;
    logic             dbz_q, dbz_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic             mode_q, mode_n;

    logic             dp_load;
    logic             dp_step;
    logic [WIDTH-1:0] dp_res;

    alu_iter_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk        (clk),
        .reset      (reset),
        .load       (dp_load),
        .step       (dp_step),
        .mode       (mode_q),
        .a          (a),
        .b          (b),
        .result_next(dp_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            dbz_q    <= 1'b0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
        end else begin
            result_q <= result_n;
            dbz_q    <= dbz_n;
            cnt_q    <= cnt_n;
            mode_q   <= mode_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        result_n = result_q;
        dbz_n    = dbz_q;
        cnt_n    = cnt_q;
        mode_n   = mode_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    unique case (1'b1)
                        op[2] || (op == OP_ADD): begin
                            result_n = a + b;
                            state_n  = ST_DONE;
                        end
                        op == OP_SUB: begin
                            result_n = a - b;
                            state_n  = ST_DONE;
                        end
                        op == OP_MUL: begin
                            dp_load = 1'b1;
                            mode_n  = 1'b0;
                            cnt_n   = CW'(WIDTH);
                            state_n = ST_CALC;
                        end
                        op == OP_DIV: begin
                            if (b == '0) begin
                                result_n = '1;
                                dbz_n    = 1'b1;
                                state_n  = ST_DONE;
                            end else begin
                                dp_load = 1'b1;
                                mode_n  = 1'b1;
                                cnt_n   = CW'(WIDTH);
                                state_n = ST_CALC;
                            end
                        end
                        default: state_n = ST_IDLE;
                    endcase
                end
            end
            ST_CALC: begin
                dp_step = 1'b1;
                cnt_n   = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_n = dp_res;
                    state_n  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    dbz_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign result      = result_q;
    assign done        = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle against an arithmetic model.
// Latency counts edges from the capture edge (inclusive) to done.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;

    alu_multicycle #(.WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .result     (result),
        .done       (done),
        .busy       (busy),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] ref_op(logic [2:0] o,
                                           logic [15:0] x,
                                           logic [15:0] y);
        int unsigned ux = x;
        int unsigned uy = y;
        int unsigned r;
        logic z = 1'b0;
        if (o[2] || o == 3'd0) r = ux + uy;
        else if (o == 3'd1) r = ux - uy;
        else if (o == 3'd2) r = ux * uy;
        else if (uy == 0) begin
            r = 32'hFFFF;
            z = 1'b1;
        end else r = ux / uy;
        return {z, r[15:0]};
    endfunction

    function automatic int ref_lat(logic [2:0] o, logic [15:0] y);
        if (o == 3'd2 || (o == 3'd3 && y != 0)) return 17;
        return 1;
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [15:0] x,
                         input logic [15:0] y, input bit scr,
                         output int lat);
        @(negedge clk);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (scr) begin
                a  = 16'($urandom);
                b  = 16'($urandom);
                op = 3'($urandom);
            end
        end
    endtask

    task automatic drop_start;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({result, done, busy, div_by_zero} !== 19'd0) begin
            bad++;
            $display("FAIL reset: got r=%h d=%b b=%b z=%b want all 0",
                     result, done, busy, div_by_zero);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_fixed(input string nm, input logic [2:0] o,
                              input logic [15:0] x, input logic [15:0] y,
                              input logic [15:0] er, input logic ez,
                              input int el);
        int lat;
        do_op(o, x, y, 1'b0, lat);
        total++;
        if (lat != el) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, lat, el);
        end
        total++;
        if (result !== er) begin
            bad++;
            $display("FAIL %s result: got %h want %h", nm, result, er);
        end
        total++;
        if (div_by_zero !== ez) begin
            bad++;
            $display("FAIL %s dbz: got %b want %b", nm, div_by_zero, ez);
        end
        drop_start();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
            bad++;
            $display("FAIL %s release: got d=%b b=%b z=%b want 0 0 0",
                     nm, done, busy, div_by_zero);
        end
        total++;
        if (result !== er) begin
            bad++;
            $display("FAIL %s retain: got %h want %h", nm, result, er);
        end
    endtask

    task automatic test_handshake;
        int lat;
        do_op(3'd2, 16'd300, 16'd300, 1'b1, lat);
        total++;
        if (lat != 17 || result !== 16'h5F90) begin
            bad++;
            $display("FAIL hs_scramble: got lat=%0d r=%h want 17 5f90",
                     lat, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a  = 16'($urandom);
            b  = 16'($urandom);
            op = 3'($urandom);
            @(posedge clk);
            #1;
            total++;
            if (done !== 1'b1 || busy !== 1'b1 || result !== 16'h5F90) begin
                bad++;
                $display("FAIL hs_hold%0d: got d=%b b=%b r=%h want 1 1 5f90",
                         i, done, busy, result);
            end
        end
        drop_start();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 16'h5F90) begin
            bad++;
            $display("FAIL hs_drop: got d=%b b=%b r=%h want 0 0 5f90",
                     done, busy, result);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        op = 3'd2;
        a = 16'd1234;
        b = 16'd567;
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL mid_busy: got b=%b d=%b want 1 0", busy, done);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({result, done, busy, div_by_zero} !== 19'd0) begin
            bad++;
            $display("FAIL mid_reset: got r=%h d=%b b=%b z=%b want all 0",
                     result, done, busy, div_by_zero);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_after: got d=%b b=%b want 0 0", done, busy);
        end
        test_fixed("post_reset_add", 3'd0, 16'hABCD, 16'h1111,
                   16'hBCDE, 1'b0, 1);
    endtask

    task automatic test_random;
        int lat;
        logic [2:0]  o;
        logic [15:0] x, y;
        logic [16:0] e;
        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            if (n % 4 == 0) o = 3'd3;
            x = 16'($urandom);
            y = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3))
                                            : 16'($urandom);
            e = ref_op(o, x, y);
            do_op(o, x, y, 1'b0, lat);
            total++;
            if (lat != ref_lat(o, y) || result !== e[15:0] ||
                div_by_zero !== e[16]) begin
                bad++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: got lat=%0d r=%h z=%b want lat=%0d r=%h z=%b",
                         n, o, x, y, lat, result, div_by_zero,
                         ref_lat(o, y), e[15:0], e[16]);
            end
            drop_start();
        end
    endtask

    initial begin
        test_reset();
        test_fixed("add", 3'd0, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 1);
        test_fixed("sub", 3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1);
        test_fixed("addr", 3'd5, 16'h0010, 16'hFFFE, 16'h000E, 1'b0, 1);
        test_fixed("mul", 3'd2, 16'd300, 16'd300, 16'h5F90, 1'b0, 17);
        test_fixed("mul_max", 3'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17);
        test_fixed("div", 3'd3, 16'd1000, 16'd7, 16'h008E, 1'b0, 17);
        test_fixed("div_big", 3'd3, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 17);
        test_fixed("div_small", 3'd3, 16'd3, 16'd9, 16'h0000, 1'b0, 17);
        test_fixed("div0", 3'd3, 16'd5, 16'd0, 16'hFFFF, 1'b1, 1);
        test_handshake();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
